// File: rtl/req_arbiter_4ch.sv
// Four-channel request arbiter with fixed-priority or round-robin selection,
// bounded grant hold time and a one-cycle dead gap between owners.
module req_arbiter_4ch #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic             rr_en,
    output logic [3:0]       gnt,
    output logic [1:0]       gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       rr_ptr;
    logic [1:0]       owner;
    logic [3:0]       owner_mask;
    logic [3:0]       others;
    logic [3:0]       cand;
    logic [1:0]       winner;
    logic [1:0]       rr_idx;

    assign owner_mask = 4'b0001 << owner;
    assign others     = req & ~owner_mask;

    // An owner that just timed out steps aside unless nobody else is asking.
    always_comb begin
        cand = req;
        if (state == RELEASE && timeout && others != 4'b0000) begin
            cand = others;
        end
    end

    always_comb begin
        winner = 2'd0;
        rr_idx = 2'd0;
        if (rr_en) begin
            for (int k = 3; k >= 0; k--) begin
                rr_idx = rr_ptr + 2'(k);
                if (cand[rr_idx]) begin
                    winner = rr_idx;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cand[i]) begin
                    winner = 2'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            rr_ptr    <= 2'd0;
            owner     <= 2'd0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, RELEASE: begin
                    if (cand != 4'b0000) begin
                        state     <= GRANT;
                        gnt       <= 4'b0001 << winner;
                        gnt_id    <= winner;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= CNT_W'(1);
                        owner     <= winner;
                        if (rr_en) begin
                            rr_ptr <= winner + 2'd1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!req[owner] || hold_cnt == CNT_W'(MAX_HOLD)) begin
                        state     <= RELEASE;
                        gnt       <= 4'b0000;
                        gnt_id    <= 2'd0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                        timeout   <= req[owner];
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter_4ch.sv
// Bench for req_arbiter_4ch: directed reset/priority/timeout checks followed by
// randomized traffic compared through a scoreboard against a behavioural model.
module tb_req_arbiter_4ch;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;
    localparam int RAND_CYCLES = 1500;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       rr_en;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
        logic       to;
    } expect_t;

    expect_t exp_q[$];
    bit      sb_on = 1'b0;
    int      checks_total  = 0;
    int      checks_passed = 0;

    int m_owner;
    int m_held;
    bit m_dead;
    int m_expired;
    int m_ptr;

    req_arbiter_4ch #(
        .MAX_HOLD(MAX_HOLD),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .rr_en    (rr_en),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] ei,
                               input logic ev, input logic et);
        checks_total++;
        if ({gnt, gnt_id, gnt_valid, timeout} === {eg, ei, ev, et}) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s @%0t: got gnt=%b id=%0d valid=%b timeout=%b, expected gnt=%b id=%0d valid=%b timeout=%b",
                     name, $time, gnt, gnt_id, gnt_valid, timeout, eg, ei, ev, et);
        end
    endtask

    function automatic int pickWinner(input int r, input bit rr, input int ptr);
        if (!rr) begin
            for (int i = 3; i >= 0; i--) if (((r >> i) & 1) == 1) return i;
        end else begin
            for (int k = 0; k < 4; k++) if (((r >> ((ptr + k) % 4)) & 1) == 1) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic modelReset();
        m_owner   = -1;
        m_held    = 0;
        m_dead    = 1'b0;
        m_expired = -1;
        m_ptr     = 0;
    endtask

    task automatic grantTo(input int r, input bit rr);
        int w;
        w = pickWinner(r, rr, m_ptr);
        if (w >= 0) begin
            m_owner = w;
            m_held  = 1;
            if (rr) m_ptr = (w + 1) % 4;
        end
    endtask

    // One clock of arbiter behaviour given the values sampled at the coming edge.
    task automatic modelStep(input int r, input bit rr);
        int c;
        if (m_owner >= 0) begin
            if (((r >> m_owner) & 1) == 0) begin
                m_dead = 1'b1; m_expired = -1; m_owner = -1;
            end else if (m_held == MAX_HOLD) begin
                m_dead = 1'b1; m_expired = m_owner; m_owner = -1;
            end else begin
                m_held++;
            end
        end else if (m_dead) begin
            c = r;
            if (m_expired >= 0 && (r & ~(1 << m_expired) & 15) != 0) c = r & ~(1 << m_expired);
            m_dead = 1'b0;
            m_expired = -1;
            grantTo(c, rr);
        end else if (r != 0) begin
            grantTo(r, rr);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic m);
        expect_t e;
        req   = r;
        rr_en = m;
        if (sb_on) begin
            modelStep(int'(r), m);
            e.g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            e.id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
            e.v  = (m_owner >= 0);
            e.to = m_dead && (m_expired >= 0);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: the DUT presents a response every cycle, popped just after the edge.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    checks_total++;
                    $display("[TB] FAIL sb_underflow @%0t: got empty queue, expected an entry", $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_random", e.g, e.id, e.v, e.to);
                end
            end
        end
    end

    initial begin
        logic [3:0] r;
        logic       m;
        rst_n = 1'b0;
        req   = 4'b0000;
        rr_en = 1'b0;
        modelReset();

        @(negedge clk);
        checkOutput("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        req   = 4'b0100;
        @(negedge clk);
        checkOutput("grant_ch2", 4'b0100, 2'd2, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1 checkOutput("async_reset_midgrant", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        req = 4'b1010;
        @(negedge clk);
        checkOutput("fixed_pick_ch3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0010;
        @(negedge clk);
        checkOutput("release_dead", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fixed_pick_ch1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        @(negedge clk);
        checkOutput("drop_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("back_to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        req = 4'b1000;
        for (int i = 0; i < MAX_HOLD; i++) begin
            @(negedge clk);
            checkOutput("sole_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
        end
        @(negedge clk);
        checkOutput("sole_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("sole_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b1001;
        for (int i = 1; i < MAX_HOLD; i++) begin
            @(negedge clk);
            checkOutput("comp_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
        end
        @(negedge clk);
        checkOutput("comp_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("comp_masked_ch0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        @(negedge clk);

        // Randomized phase starts from a fresh reset so the model is in step.
        rst_n = 1'b0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        sb_on = 1'b1;
        r = 4'b1111;
        m = 1'b1;
        applyStimulus(r, m);
        for (int c = 0; c < RAND_CYCLES; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) m = ~m;
            @(negedge clk);
            applyStimulus(r, m);
        end
        @(posedge clk);
        #2;
        sb_on = 1'b0;
        checks_total++;
        if (exp_q.size() == 0) checks_passed++;
        else $display("[TB] FAIL sb_drain: got %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
